lcd_hd44780_ctrl: RTL and testbench

Timing engine for the board's HD44780-compatible character LCD, sitting on the peripheral side of the LSU's LCD output path. Software writes a command or data byte through a valid/ready handshake. The block generates the LCD bus phases: RS/DATA setup, EN pulse, hold, and the controller's execution wait. It also runs the power-on initialisation sequence by itself. A packed status word is produced in the same layout as the core's LCD I/O register, so the word can be mirrored straight onto the LCD output port.

---
 rtl/lcd_hd44780_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_ctrl
//
// Timing engine for an HD44780-compatible character LCD. It drives the bus
// phases of each write: RS/DATA setup, EN pulse, hold, and the controller's
// execution wait. After reset it runs the power-on init sequence
// (0x38, 0x0C, 0x01, 0x06) without help from software. When init is complete,
// it accepts instruction or data bytes through a valid/ready handshake.
//
// Parameters (all counts in clk cycles, each >= 1):
//   T_PWR    power-on wait before the first init command
//   T_SETUP  RS/DATA valid before EN rises
//   T_PULSE  EN high width
//   T_HOLD   RS/DATA held after EN falls
//   T_CMD    execution wait after a normal command or data write
//   T_CLR    execution wait after clear/home (RS=0, data 0x01..0x03)
//
// Ports:
//   i_clk, i_reset   clock; synchronous active-high reset
//   i_cmd_vld        request valid
//   i_cmd_rs         0 = instruction, 1 = data
//   i_cmd_data       byte to send
//   o_cmd_rdy        high only while idle; a request is taken on vld & rdy
//   o_init_done      init sequence complete; sticky until reset
//   o_lcd_on         LCD power/backlight enable
//   o_lcd_en         LCD EN strobe
//   o_lcd_rs         LCD RS
//   o_lcd_rw         LCD R/W; tied to write
//   o_lcd_data       LCD DB7..DB0
//   o_io_lcd         packed status word: [31]=ON [10]=EN [9]=RS [8]=RW [7:0]=DATA
// -----------------------------------------------------------------------------
module lcd_hd44780_ctrl #(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 2,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_vld,
  input  logic        i_cmd_rs,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_rdy,
  output logic        o_init_done,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic [31:0] o_io_lcd
);

  // The counter only ever holds (parameter - 1), so clog2 of the largest
  // parameter is enough.
  localparam int MAX_A = (T_PWR   > T_CLR)   ? T_PWR   : T_CLR;
  localparam int MAX_B = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int MAX_C = (T_HOLD  > T_CMD)   ? T_HOLD  : T_CMD;
  localparam int MAX_D = (MAX_A   > MAX_B)   ? MAX_A   : MAX_B;
  localparam int MAX_P = (MAX_D   > MAX_C)   ? MAX_D   : MAX_C;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] C_PWR   = CW'(T_PWR - 1);
  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] C_CLR   = CW'(T_CLR - 1);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    LOAD     = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    HOLD     = 3'd4,
    WAIT     = 3'd5,
    IDLE     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          on_q, on_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;

  logic          long_wait;
  logic [7:0]    init_byte;

  // Clear and home instructions need the long execution wait.
  assign long_wait = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) ||
                               (data_q == 8'h03));

  // Power-on init ROM: function set 8-bit/2-line, display on,
  // clear, entry mode increment.
  always_comb begin
    init_byte = 8'h38;
    case (init_idx_q)
      2'd0: init_byte = 8'h38;
      2'd1: init_byte = 8'h0C;
      2'd2: init_byte = 8'h01;
      2'd3: init_byte = 8'h06;
      default: init_byte = 8'h38;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    on_d        = 1'b1;
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;
    rdy_d       = rdy_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - CW'(1);
      end

      LOAD: begin
        rs_d    = 1'b0;
        data_d  = init_byte;
        cnt_d   = C_SETUP;
        state_d = SETUP;
      end

      SETUP: begin
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          cnt_d   = C_PULSE;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = C_HOLD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = long_wait ? C_CLR : C_CMD;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          // During init, go on to the next ROM entry until the fourth entry is done.
          if (!init_done_q && (init_idx_q != 2'd3)) begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = LOAD;
          end else begin
            init_done_d = 1'b1;
            rdy_d       = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      IDLE: begin
        if (i_cmd_vld && rdy_q) begin
          rs_d    = i_cmd_rs;
          data_d  = i_cmd_data;
          rdy_d   = 1'b0;
          cnt_d   = C_SETUP;
          state_d = SETUP;
        end
      end

      default: begin
        state_d = PWR_WAIT;
        cnt_d   = C_PWR;
        en_d    = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= C_PWR;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      on_q        <= on_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
    end
  end

  assign o_cmd_rdy   = rdy_q;
  assign o_init_done = init_done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;
  assign o_io_lcd    = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_hd44780_ctrl
//
// Directed bench for lcd_hd44780_ctrl with short timing parameters
// (T_PWR=5, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_CMD=10, T_CLR=30).
// A negedge monitor logs every EN pulse (rise time, width, RS, DATA) and
// counts bus-stability violations. The main thread drives requests and
// checks the results against hand-computed cycle counts.
// -----------------------------------------------------------------------------
module tb_lcd_hd44780_ctrl;

  localparam int T_PWR   = 5;
  localparam int T_SETUP = 2;
  localparam int T_PULSE = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;
  // Init completes after T_PWR + 3*18 + 38 + 4 = 101 edges.
  localparam int INIT_EDGES = 101;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_vld;
  logic        cmd_rs;
  logic [7:0]  cmd_data;
  logic        cmd_rdy;
  logic        init_done;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic [31:0] io_lcd;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
    .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_cmd_vld(cmd_vld),
    .i_cmd_rs(cmd_rs),
    .i_cmd_data(cmd_data),
    .o_cmd_rdy(cmd_rdy),
    .o_init_done(init_done),
    .o_lcd_on(lcd_on),
    .o_lcd_en(lcd_en),
    .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data),
    .o_io_lcd(io_lcd)
  );

  // ---------------- EN pulse monitor ----------------
  int         mcyc = 0;
  int         npulse = 0;
  int         viol = 0;
  int         p_rise  [64];
  int         p_width [64];
  logic [7:0] p_data  [64];
  logic       p_rs    [64];
  logic       en_prev = 1'b0;
  logic [7:0] d_prev = 8'h00;
  logic       rs_prev = 1'b0;

  always @(negedge clk) begin
    mcyc++;
    if (lcd_en && !en_prev && npulse < 64) begin
      p_rise[npulse]  = mcyc;
      p_width[npulse] = 0;
      p_data[npulse]  = lcd_data;
      p_rs[npulse]    = lcd_rs;
      npulse++;
    end
    if (!lcd_en && en_prev && npulse > 0)
      p_width[npulse-1] = mcyc - p_rise[npulse-1];
    if (lcd_en && en_prev && (lcd_data != d_prev || lcd_rs != rs_prev))
      viol++;
    if (mcyc > 2 && lcd_rw !== 1'b0)
      viol++;
    en_prev = lcd_en;
    d_prev  = lcd_data;
    rs_prev = lcd_rs;
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release reset and count edges until init_done rises (bounded).
  task automatic do_init(output int n, output int rdy_early, output int on_first);
    n = 0;
    rdy_early = 0;
    on_first = 0;
    reset = 1'b0;
    while (!init_done && n < 400) begin
      step();
      n++;
      if (n == 1) on_first = int'(lcd_on);
      if (cmd_rdy && !init_done) rdy_early = 1;
    end
  endtask

  task automatic check_init(input string pfx, input int base);
    int n, rdy_early, on_first;
    do_init(n, rdy_early, on_first);
    check_eq({pfx, "_on_first_edge"}, 32'(on_first), 32'd1);
    check_eq({pfx, "_done_edge"}, 32'(n), 32'(INIT_EDGES));
    check_eq({pfx, "_rdy_early"}, 32'(rdy_early), 32'd0);
    check_eq({pfx, "_rdy_with_done"}, 32'(cmd_rdy), 32'd1);
    check_eq({pfx, "_pulse_cnt"}, 32'(npulse - base), 32'd4);
    check_eq({pfx, "_d0"}, 32'(p_data[base]),   32'h38);
    check_eq({pfx, "_d1"}, 32'(p_data[base+1]), 32'h0C);
    check_eq({pfx, "_d2"}, 32'(p_data[base+2]), 32'h01);
    check_eq({pfx, "_d3"}, 32'(p_data[base+3]), 32'h06);
    check_eq({pfx, "_rs_any"},
             32'({p_rs[base], p_rs[base+1], p_rs[base+2], p_rs[base+3]}), 32'd0);
    check_eq({pfx, "_width0"}, 32'(p_width[base]), 32'd4);
    check_eq({pfx, "_gap01"}, 32'(p_rise[base+1] - p_rise[base]), 32'd19);
    check_eq({pfx, "_gap12"}, 32'(p_rise[base+2] - p_rise[base+1]), 32'd19);
    // Clear uses the 30-cycle wait: 2+4+2+30+1 LOAD cycle between rises.
    check_eq({pfx, "_gap23"}, 32'(p_rise[base+3] - p_rise[base+2]), 32'd39);
  endtask

  // Issue one request from IDLE and observe it until rdy returns (bounded).
  task automatic run_cmd(input logic rs, input logic [7:0] data,
                         output int rdy_after, output int en_first,
                         output int en_cnt, output int rdy_at,
                         output logic [31:0] io_pulse);
    rdy_after = -1; en_first = -1; en_cnt = 0; rdy_at = -1; io_pulse = '0;
    cmd_vld = 1'b1; cmd_rs = rs; cmd_data = data;
    step();
    cmd_vld = 1'b0;
    rdy_after = int'(cmd_rdy);
    for (int j = 1; j <= 80 && rdy_at < 0; j++) begin
      step();
      if (lcd_en) begin
        if (en_first < 0) begin
          en_first = j;
          io_pulse = io_lcd;
        end
        en_cnt++;
      end
      if (cmd_rdy) rdy_at = j;
    end
  endtask

  task automatic wait_rdy(output int ok);
    ok = 0;
    for (int j = 0; j < 80 && !cmd_rdy; j++) step();
    if (cmd_rdy) ok = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rdy_after, en_first, en_cnt, rdy_at, ok, base;
    logic [31:0] io_pulse;

    reset = 1'b1; cmd_vld = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    repeat (3) step();
    check_eq("rst_io", io_lcd, 32'h0);
    check_eq("rst_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("rst_done", 32'(init_done), 32'd0);
    check_eq("rst_rw", 32'(lcd_rw), 32'd0);

    // Power-on init
    base = npulse;
    check_init("init", base);

    // Data write 0x41
    run_cmd(1'b1, 8'h41, rdy_after, en_first, en_cnt, rdy_at, io_pulse);
    check_eq("wr_rdy_drop", 32'(rdy_after), 32'd0);
    check_eq("wr_en_first", 32'(en_first), 32'd2);
    check_eq("wr_en_cnt", 32'(en_cnt), 32'd4);
    check_eq("wr_io_pulse", io_pulse, 32'h8000_0641);
    check_eq("wr_rdy_at", 32'(rdy_at), 32'd18);
    check_eq("wr_io_after", io_lcd, 32'h8000_0241);

    // Clear (long wait) and the same byte as data (short wait)
    run_cmd(1'b0, 8'h01, rdy_after, en_first, en_cnt, rdy_at, io_pulse);
    check_eq("clr_rdy_at", 32'(rdy_at), 32'd38);
    check_eq("clr_io_pulse", io_pulse, 32'h8000_0401);
    run_cmd(1'b1, 8'h01, rdy_after, en_first, en_cnt, rdy_at, io_pulse);
    check_eq("d01_rdy_at", 32'(rdy_at), 32'd18);
    run_cmd(1'b0, 8'h02, rdy_after, en_first, en_cnt, rdy_at, io_pulse);
    check_eq("home_rdy_at", 32'(rdy_at), 32'd38);
    run_cmd(1'b0, 8'h04, rdy_after, en_first, en_cnt, rdy_at, io_pulse);
    check_eq("cmd04_rdy_at", 32'(rdy_at), 32'd18);

    // Stream: vld held high across two requests
    base = npulse;
    cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h48;
    step();
    cmd_data = 8'h49;
    for (int j = 0; j < 40 && !cmd_rdy; j++) step();
    step();
    cmd_vld = 1'b0;
    check_eq("stream_acc2_rdy", 32'(cmd_rdy), 32'd0);
    wait_rdy(ok);
    check_eq("stream_rdy_back", 32'(ok), 32'd1);
    check_eq("stream_pulses", 32'(npulse - base), 32'd2);
    check_eq("stream_d0", 32'(p_data[base]), 32'h48);
    check_eq("stream_d1", 32'(p_data[base+1]), 32'h49);
    check_eq("stream_gap", 32'(p_rise[base+1] - p_rise[base]), 32'd19);

    // Busy: a one-cycle request while rdy=0 must be ignored
    base = npulse;
    cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h42;
    step();
    cmd_vld = 1'b0;
    repeat (7) step();
    cmd_vld = 1'b1; cmd_data = 8'h55;
    step();
    cmd_vld = 1'b0;
    wait_rdy(ok);
    repeat (3) step();
    check_eq("busy_rdy_back", 32'(ok), 32'd1);
    check_eq("busy_pulses", 32'(npulse - base), 32'd1);
    check_eq("busy_data", 32'(lcd_data), 32'h42);
    check_eq("busy_log_data", 32'(p_data[base]), 32'h42);
    check_eq("bus_stable_viol", 32'(viol), 32'd0);

    // Reset in the middle of an EN pulse
    cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h43;
    step();
    cmd_vld = 1'b0;
    repeat (3) step();
    check_eq("mid_en_high", 32'(lcd_en), 32'd1);
    reset = 1'b1;
    step();
    check_eq("mid_rst_en", 32'(lcd_en), 32'd0);
    check_eq("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("mid_rst_done", 32'(init_done), 32'd0);
    check_eq("mid_rst_on", 32'(lcd_on), 32'd0);
    check_eq("mid_rst_io", io_lcd, 32'h0);
    base = npulse;
    check_init("reinit", base);
    check_eq("final_viol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Overall watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
